// File: rtl/alien_spawn_scheduler.sv
// Alien spawn scheduler: releases alien slots on a frame cadence, tracks kills
// against a per-level budget, freezes and refunds live slots on player death,
// and flags level completion once the budget is spent and every alien is dead.
module alien_spawn_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int MAX_ACTIVE     = 3,
  parameter int LEVEL_BUDGET   = 8,
  parameter int SPAWN_INTERVAL = 60,
  parameter int PAUSE_FRAMES   = 90
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 level_start,
  input  logic [NUM_SLOTS-1:0] alien_died,
  input  logic                 player_died,
  output logic [NUM_SLOTS-1:0] spawn_req,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic                 freeze,
  output logic [7:0]           aliens_remaining,
  output logic [7:0]           kill_count,
  output logic                 level_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  localparam logic [9:0] SPAWN_LIM = 10'(SPAWN_INTERVAL);
  localparam logic [9:0] PAUSE_LIM = 10'(PAUSE_FRAMES);
  localparam logic [7:0] BUDGET    = 8'(LEVEL_BUDGET);
  localparam logic [3:0] MAX_ACT   = 4'(MAX_ACTIVE);

  function automatic logic [3:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // One-hot of the lowest clear bit (two's-complement isolate on the inverted vector).
  function automatic logic [NUM_SLOTS-1:0] lowest_free(input logic [NUM_SLOTS-1:0] act);
    logic [NUM_SLOTS-1:0] free;
    free = ~act;
    return free & (~free + NUM_SLOTS'(1));
  endfunction

  state_t               state_q, state_d;
  logic [9:0]           frame_cnt_q, frame_cnt_d;
  logic [NUM_SLOTS-1:0] spawn_req_q, spawn_req_d;
  logic [NUM_SLOTS-1:0] slot_active_q, slot_active_d;
  logic                 freeze_q, freeze_d;
  logic [7:0]           remaining_q, remaining_d;
  logic [7:0]           kill_count_q, kill_count_d;
  logic                 level_done_q, level_done_d;

  logic [NUM_SLOTS-1:0] kills;
  logic [NUM_SLOTS-1:0] pick;
  logic [8:0]           kill_sum;
  logic [7:0]           kill_sat;
  logic [8:0]           refund_sum;
  logic [7:0]           refund_sat;
  logic                 spawn_ok;

  // Next-state and output computation for the level sequencer.
  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    spawn_req_d   = '0;
    slot_active_d = slot_active_q;
    freeze_d      = freeze_q;
    remaining_d   = remaining_q;
    kill_count_d  = kill_count_q;
    level_done_d  = level_done_q;

    kills      = alien_died & slot_active_q;
    pick       = lowest_free(slot_active_q);
    kill_sum   = {1'b0, kill_count_q} + {5'b00000, popcount(kills)};
    kill_sat   = kill_sum[8] ? 8'hFF : kill_sum[7:0];
    // Refund counts every slot alive before the death, including ones killed this cycle.
    refund_sum = {1'b0, remaining_q} + {5'b00000, popcount(slot_active_q)};
    refund_sat = (refund_sum > {1'b0, BUDGET}) ? BUDGET : refund_sum[7:0];
    // Free-slot and occupancy checks use registered state, so a slot freed
    // this cycle only becomes spawnable next cycle.
    spawn_ok   = startOfFrame && (frame_cnt_q == SPAWN_LIM) && (remaining_q != '0) &&
                 (popcount(slot_active_q) < MAX_ACT) && (|(~slot_active_q));

    if (level_start) begin
      state_d       = ST_RUN;
      frame_cnt_d   = '0;
      slot_active_d = '0;
      freeze_d      = 1'b0;
      remaining_d   = BUDGET;
      kill_count_d  = '0;
      level_done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (player_died) begin
            state_d       = ST_PAUSE;
            kill_count_d  = kill_sat;
            remaining_d   = refund_sat;
            slot_active_d = '0;
            frame_cnt_d   = '0;
            freeze_d      = 1'b1;
          end else if ((remaining_q == '0) && (slot_active_q == '0)) begin
            state_d      = ST_DONE;
            level_done_d = 1'b1;
          end else begin
            kill_count_d  = kill_sat;
            slot_active_d = slot_active_q & ~kills;
            if (spawn_ok) begin
              spawn_req_d   = pick;
              slot_active_d = slot_active_d | pick;
              remaining_d   = remaining_q - 8'd1;
              frame_cnt_d   = '0;
            end else if (startOfFrame && (frame_cnt_q < SPAWN_LIM)) begin
              frame_cnt_d = frame_cnt_q + 10'd1;
            end
          end
        end
        ST_PAUSE: begin
          if (startOfFrame) begin
            if ((frame_cnt_q + 10'd1) == PAUSE_LIM) begin
              state_d     = ST_RUN;
              frame_cnt_d = '0;
              freeze_d    = 1'b0;
            end else begin
              frame_cnt_d = frame_cnt_q + 10'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      frame_cnt_q   <= '0;
      spawn_req_q   <= '0;
      slot_active_q <= '0;
      freeze_q      <= 1'b0;
      remaining_q   <= '0;
      kill_count_q  <= '0;
      level_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      spawn_req_q   <= spawn_req_d;
      slot_active_q <= slot_active_d;
      freeze_q      <= freeze_d;
      remaining_q   <= remaining_d;
      kill_count_q  <= kill_count_d;
      level_done_q  <= level_done_d;
    end
  end

  assign spawn_req        = spawn_req_q;
  assign slot_active      = slot_active_q;
  assign freeze           = freeze_q;
  assign aliens_remaining = remaining_q;
  assign kill_count       = kill_count_q;
  assign level_done       = level_done_q;

endmodule

// File: tb/tb_alien_spawn_scheduler.sv
// Bench for alien_spawn_scheduler: directed sequences on a default-parameter
// instance, a vector table and a randomized model comparison on a small instance.
module tb_alien_spawn_scheduler;

  localparam int NS     = 4;
  localparam int B_MAXA = 2;
  localparam int B_BUD  = 2;
  localparam int B_SI   = 2;
  localparam int B_PF   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_sof, a_ls, a_pd, a_frz, a_done;
  logic [3:0] a_ad, a_spawn, a_act;
  logic [7:0] a_rem, a_kill;

  logic       b_rst, b_sof, b_ls, b_pd, b_frz, b_done;
  logic [3:0] b_ad, b_spawn, b_act;
  logic [7:0] b_rem, b_kill;

  int checks   = 0;
  int failures = 0;

  alien_spawn_scheduler #(
    .NUM_SLOTS(4), .MAX_ACTIVE(3), .LEVEL_BUDGET(8),
    .SPAWN_INTERVAL(60), .PAUSE_FRAMES(90)
  ) u_a (
    .clk(clk), .reset(a_rst), .startOfFrame(a_sof), .level_start(a_ls),
    .alien_died(a_ad), .player_died(a_pd), .spawn_req(a_spawn),
    .slot_active(a_act), .freeze(a_frz), .aliens_remaining(a_rem),
    .kill_count(a_kill), .level_done(a_done)
  );

  alien_spawn_scheduler #(
    .NUM_SLOTS(NS), .MAX_ACTIVE(B_MAXA), .LEVEL_BUDGET(B_BUD),
    .SPAWN_INTERVAL(B_SI), .PAUSE_FRAMES(B_PF)
  ) u_b (
    .clk(clk), .reset(b_rst), .startOfFrame(b_sof), .level_start(b_ls),
    .alien_died(b_ad), .player_died(b_pd), .spawn_req(b_spawn),
    .slot_active(b_act), .freeze(b_frz), .aliens_remaining(b_rem),
    .kill_count(b_kill), .level_done(b_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- DUT A helpers ----------------
  task automatic a_cyc();
    @(posedge clk);
    #1;
    a_rst = 1'b0; a_sof = 1'b0; a_ls = 1'b0; a_pd = 1'b0; a_ad = '0;
  endtask

  task automatic a_frame(output logic [3:0] sp);
    a_sof = 1'b1;
    a_cyc();
    sp = a_spawn;
    a_cyc();
  endtask

  task automatic a_wait_spawn(input int max_frames, output int n, output logic [3:0] sp);
    logic [3:0] s;
    n  = 0;
    sp = '0;
    for (int i = 1; i <= max_frames; i++) begin
      a_frame(s);
      if (s != 4'h0) begin
        n  = i;
        sp = s;
        break;
      end
    end
  endtask

  task automatic a_check_all_zero(input string tag);
    chk({tag, "_spawn"}, 32'(a_spawn), 0);
    chk({tag, "_active"}, 32'(a_act), 0);
    chk({tag, "_freeze"}, 32'(a_frz), 0);
    chk({tag, "_remaining"}, 32'(a_rem), 0);
    chk({tag, "_kills"}, 32'(a_kill), 0);
    chk({tag, "_done"}, 32'(a_done), 0);
  endtask

  // ---------------- Vector table for DUT B ----------------
  typedef struct {
    logic       rst, sof, ls, pd;
    logic [3:0] ad;
    logic [3:0] sp, act;
    logic       frz;
    logic [7:0] rem, kill;
    logic       done;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl[NV];

  // ---------------- Reference model for DUT B ----------------
  // phase: 0 idle, 1 running, 2 paused, 3 finished
  int m_phase, m_frames, m_rem, m_kills;
  bit m_alive[NS];
  bit m_spawn[NS];
  bit m_frz, m_done;

  function automatic logic [3:0] pack(input bit v[NS]);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < NS; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic model_step(input bit rst, input bit sof, input bit ls, input bit pd,
                            input logic [3:0] ad);
    int died, nalive, free;
    for (int i = 0; i < NS; i++) m_spawn[i] = 1'b0;
    if (rst) begin
      m_phase = 0; m_frames = 0; m_rem = 0; m_kills = 0; m_frz = 0; m_done = 0;
      for (int i = 0; i < NS; i++) m_alive[i] = 1'b0;
    end else if (ls) begin
      m_phase = 1; m_frames = 0; m_rem = B_BUD; m_kills = 0; m_frz = 0; m_done = 0;
      for (int i = 0; i < NS; i++) m_alive[i] = 1'b0;
    end else if (m_phase == 1) begin
      died = 0; nalive = 0; free = -1;
      for (int i = 0; i < NS; i++) begin
        if (m_alive[i]) begin
          nalive++;
          if (ad[i]) died++;
        end else if (free < 0) begin
          free = i;
        end
      end
      if (pd) begin
        m_kills  = (m_kills + died > 255) ? 255 : m_kills + died;
        m_rem    = (m_rem + nalive > B_BUD) ? B_BUD : m_rem + nalive;
        for (int i = 0; i < NS; i++) m_alive[i] = 1'b0;
        m_frames = 0; m_frz = 1; m_phase = 2;
      end else if (m_rem == 0 && nalive == 0) begin
        m_phase = 3; m_done = 1;
      end else begin
        m_kills = (m_kills + died > 255) ? 255 : m_kills + died;
        for (int i = 0; i < NS; i++) if (m_alive[i] && ad[i]) m_alive[i] = 1'b0;
        if (sof && m_frames == B_SI && m_rem > 0 && nalive < B_MAXA && free >= 0) begin
          m_alive[free] = 1'b1;
          m_spawn[free] = 1'b1;
          m_rem--;
          m_frames = 0;
        end else if (sof && m_frames < B_SI) begin
          m_frames++;
        end
      end
    end else if (m_phase == 2) begin
      if (sof) begin
        m_frames++;
        if (m_frames == B_PF) begin
          m_phase = 1; m_frames = 0; m_frz = 0;
        end
      end
    end
  endtask

  initial begin
    int         n;
    logic [3:0] sp;
    vec_t       v;
    bit         r_rst, r_sof, r_ls, r_pd;
    logic [3:0] r_ad;

    a_rst = 1'b1; a_sof = 1'b0; a_ls = 1'b0; a_pd = 1'b0; a_ad = '0;
    b_rst = 1'b1; b_sof = 1'b0; b_ls = 1'b0; b_pd = 1'b0; b_ad = '0;

    // ---- DUT A: reset state ----
    a_cyc();
    a_check_all_zero("reset");

    // ---- DUT A: spawn cadence and MAX_ACTIVE limit ----
    a_ls = 1'b1; a_cyc();
    chk("start_remaining", 32'(a_rem), 8);
    chk("start_kills", 32'(a_kill), 0);
    a_wait_spawn(100, n, sp);
    chk("spawn1_frames", n, 61); chk("spawn1_slot", 32'(sp), 4'b0001);
    a_wait_spawn(100, n, sp);
    chk("spawn2_frames", n, 61); chk("spawn2_slot", 32'(sp), 4'b0010);
    a_wait_spawn(100, n, sp);
    chk("spawn3_frames", n, 61); chk("spawn3_slot", 32'(sp), 4'b0100);
    a_wait_spawn(100, n, sp);
    chk("max_active_blocks", n, 0);
    chk("max_active_remaining", 32'(a_rem), 5);
    chk("max_active_slots", 32'(a_act), 4'b0111);

    // ---- DUT A: kill frees a slot, saturated counter respawns it next frame ----
    a_ad = 4'b0010; a_cyc();
    chk("kill1_active", 32'(a_act), 4'b0101);
    chk("kill1_kills", 32'(a_kill), 1);
    a_frame(sp);
    chk("respawn_slot", 32'(sp), 4'b0010);
    chk("respawn_remaining", 32'(a_rem), 4);

    // ---- DUT A: death pulse on an inactive slot ----
    a_ad = 4'b1000; a_cyc();
    chk("inactive_kill_active", 32'(a_act), 4'b0111);
    chk("inactive_kill_kills", 32'(a_kill), 1);
    chk("inactive_kill_remaining", 32'(a_rem), 4);

    // ---- DUT A: player death with same-cycle alien death, then pause ----
    a_ad = 4'b0100; a_cyc();
    chk("kill2_active", 32'(a_act), 4'b0011);
    a_pd = 1'b1; a_ad = 4'b0001; a_cyc();
    chk("pdeath_freeze", 32'(a_frz), 1);
    chk("pdeath_kills", 32'(a_kill), 3);
    chk("pdeath_refund", 32'(a_rem), 6);
    chk("pdeath_active", 32'(a_act), 0);
    a_pd = 1'b1; a_ad = 4'b1111; a_cyc();
    chk("pause_ignore_kills", 32'(a_kill), 3);
    chk("pause_ignore_remaining", 32'(a_rem), 6);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      a_frame(sp);
      if (!a_frz) begin
        n = i;
        break;
      end
    end
    chk("pause_frames", n, 90);
    a_wait_spawn(100, n, sp);
    chk("post_pause_frames", n, 61); chk("post_pause_slot", 32'(sp), 4'b0001);
    chk("post_pause_remaining", 32'(a_rem), 5);

    // ---- DUT A: reset mid-run with two slots active ----
    a_wait_spawn(100, n, sp);
    chk("pre_reset_slot", 32'(sp), 4'b0010);
    chk("pre_reset_active", 32'(a_act), 4'b0011);
    a_rst = 1'b1; a_cyc();
    a_check_all_zero("midrun_reset");
    a_wait_spawn(70, n, sp);
    chk("idle_no_spawn", n, 0);

    // ---- DUT B: vector table ----
    //            rst  sof  ls   pd   ad      sp      act     frz  rem kill done
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,4'h0,  4'h0,4'h0,  1'b0,8'd0,8'd0,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b1,1'b0,4'h0,  4'h0,4'h0,  1'b0,8'd2,8'd0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h0,4'h0,  1'b0,8'd2,8'd0,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h0,4'h0,  1'b0,8'd2,8'd0,1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h1,4'h1,  1'b0,8'd1,8'd0,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,4'h0,  4'h0,4'h1,  1'b0,8'd1,8'd0,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h0,4'h1,  1'b0,8'd1,8'd0,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h0,4'h1,  1'b0,8'd1,8'd0,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h2,4'h3,  1'b0,8'd0,8'd0,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,4'h4,  4'h0,4'h3,  1'b0,8'd0,8'd0,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,4'h3,  4'h0,4'h0,  1'b0,8'd0,8'd2,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b0,4'h0,  4'h0,4'h0,  1'b0,8'd0,8'd2,1'b1};
    tbl[12] = '{1'b0,1'b1,1'b0,1'b1,4'h0,  4'h0,4'h0,  1'b0,8'd0,8'd2,1'b1};
    tbl[13] = '{1'b0,1'b0,1'b1,1'b0,4'h0,  4'h0,4'h0,  1'b0,8'd2,8'd0,1'b0};
    tbl[14] = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h0,4'h0,  1'b0,8'd2,8'd0,1'b0};
    tbl[15] = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h0,4'h0,  1'b0,8'd2,8'd0,1'b0};
    tbl[16] = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h1,4'h1,  1'b0,8'd1,8'd0,1'b0};
    tbl[17] = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h0,4'h1,  1'b0,8'd1,8'd0,1'b0};
    tbl[18] = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h0,4'h1,  1'b0,8'd1,8'd0,1'b0};
    tbl[19] = '{1'b0,1'b1,1'b0,1'b0,4'h1,  4'h2,4'h2,  1'b0,8'd0,8'd1,1'b0};
    tbl[20] = '{1'b0,1'b0,1'b0,1'b1,4'h2,  4'h0,4'h0,  1'b1,8'd1,8'd2,1'b0};
    tbl[21] = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h0,4'h0,  1'b1,8'd1,8'd2,1'b0};
    tbl[22] = '{1'b0,1'b0,1'b0,1'b1,4'hF,  4'h0,4'h0,  1'b1,8'd1,8'd2,1'b0};
    tbl[23] = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h0,4'h0,  1'b1,8'd1,8'd2,1'b0};
    tbl[24] = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h0,4'h0,  1'b0,8'd1,8'd2,1'b0};
    tbl[25] = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h0,4'h0,  1'b0,8'd1,8'd2,1'b0};
    tbl[26] = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h0,4'h0,  1'b0,8'd1,8'd2,1'b0};
    tbl[27] = '{1'b0,1'b1,1'b0,1'b0,4'h0,  4'h1,4'h1,  1'b0,8'd0,8'd2,1'b0};
    tbl[28] = '{1'b0,1'b0,1'b1,1'b0,4'h0,  4'h0,4'h0,  1'b0,8'd2,8'd0,1'b0};

    for (int r = 0; r < NV; r++) begin
      v = tbl[r];
      b_rst = v.rst; b_sof = v.sof; b_ls = v.ls; b_pd = v.pd; b_ad = v.ad;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_spawn", r), 32'(b_spawn), 32'(v.sp));
      chk($sformatf("row%0d_active", r), 32'(b_act), 32'(v.act));
      chk($sformatf("row%0d_freeze", r), 32'(b_frz), 32'(v.frz));
      chk($sformatf("row%0d_remaining", r), 32'(b_rem), 32'(v.rem));
      chk($sformatf("row%0d_kills", r), 32'(b_kill), 32'(v.kill));
      chk($sformatf("row%0d_done", r), 32'(b_done), 32'(v.done));
    end

    // ---- DUT B: randomized run against the reference model ----
    for (int c = 0; c < 3000; c++) begin
      r_rst = (c == 0) || ($urandom_range(299) == 0);
      r_ls  = (c == 1) || ($urandom_range(49) == 0);
      r_pd  = ($urandom_range(39) == 0);
      r_sof = ($urandom_range(1) == 0);
      for (int i = 0; i < NS; i++) r_ad[i] = ($urandom_range(5) == 0);
      b_rst = r_rst; b_sof = r_sof; b_ls = r_ls; b_pd = r_pd; b_ad = r_ad;
      model_step(r_rst, r_sof, r_ls, r_pd, r_ad);
      @(posedge clk);
      #1;
      chk($sformatf("rand%0d_spawn", c), 32'(b_spawn), 32'(pack(m_spawn)));
      chk($sformatf("rand%0d_active", c), 32'(b_act), 32'(pack(m_alive)));
      chk($sformatf("rand%0d_freeze", c), 32'(b_frz), 32'(m_frz));
      chk($sformatf("rand%0d_remaining", c), 32'(b_rem), 32'(m_rem));
      chk($sformatf("rand%0d_kills", c), 32'(b_kill), 32'(m_kills));
      chk($sformatf("rand%0d_done", c), 32'(b_done), 32'(m_done));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
